// File: rtl/step_seq_pkg.sv
// Shared constants for the step sequencer: FSM encoding, pattern width, LED map.
// Optional macro STEP_SEQ_CTRL_LOOP_EN (used by step_seq_ctrl) selects looping auto-play.
package step_seq_pkg;

  localparam int PATTERN_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_GAP  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // ledr field offsets
  localparam int LED_PAT_LSB   = 0;
  localparam int LED_IDX_LSB   = 8;
  localparam int LED_BUSY      = 11;
  localparam int LED_DIN       = 12;
  localparam int LED_STATE_LSB = 13;
  localparam int LED_ZERO      = 15;

endpackage

// File: rtl/btn_debounce.sv
// Button conditioning: 2-flop synchronizer, counting debouncer, rising-edge press pulse.
module btn_debounce #(
  parameter int DEB_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic db,
  output logic press
);

  logic        sync1_reg;
  logic        sync2_reg;
  logic        db_reg;
  logic        press_reg;
  logic [15:0] cnt_reg;

  // cnt_reg counts consecutive synchronized samples that disagree with db_reg
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_reg <= 1'b0;
      sync2_reg <= 1'b0;
      db_reg    <= 1'b0;
      press_reg <= 1'b0;
      cnt_reg   <= 16'd0;
    end else begin
      sync1_reg <= btn;
      sync2_reg <= sync1_reg;
      press_reg <= 1'b0;
      if (sync2_reg == db_reg) begin
        cnt_reg <= 16'd0;
      end else if (cnt_reg == 16'(DEB_CYCLES - 1)) begin
        db_reg    <= sync2_reg;
        press_reg <= sync2_reg;
        cnt_reg   <= 16'd0;
      end else begin
        cnt_reg <= cnt_reg + 16'd1;
      end
    end
  end

  assign db    = db_reg;
  assign press = press_reg;

endmodule

// File: rtl/step_seq_ctrl.sv
// Step/auto-play controller feeding a downstream sequence detector.
// Define STEP_SEQ_CTRL_LOOP_EN to make auto-play repeat until stopped.
module step_seq_ctrl
  import step_seq_pkg::*;
#(
  parameter int DEB_CYCLES = 16,
  parameter int PLAY_DIV   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        btn_step,
  input  logic        btn_play,
  input  logic        sw_din,
  input  logic [7:0]  pattern,
  output logic        step_en,
  output logic        step_din,
  output logic        busy,
  output logic [15:0] ledr
);

  logic step_press;
  logic play_press;
  logic step_db;
  logic play_db;

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_step (
    .clk  (clk),
    .rst  (rst),
    .btn  (btn_step),
    .db   (step_db),
    .press(step_press)
  );

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_play (
    .clk  (clk),
    .rst  (rst),
    .btn  (btn_play),
    .db   (play_db),
    .press(play_press)
  );

  state_t                 state_reg, state_next;
  logic [PATTERN_W-1:0]   pattern_q_reg, pattern_q_next;
  logic [2:0]             bit_idx_reg, bit_idx_next;
  logic [15:0]            gap_cnt_reg, gap_cnt_next;
  logic                   man_step_reg, man_step_next;
  logic                   man_din_reg, man_din_next;
  logic                   last_din_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      pattern_q_reg <= '0;
      bit_idx_reg   <= 3'd0;
      gap_cnt_reg   <= 16'd0;
      man_step_reg  <= 1'b0;
      man_din_reg   <= 1'b0;
      last_din_reg  <= 1'b0;
    end else begin
      state_reg     <= state_next;
      pattern_q_reg <= pattern_q_next;
      bit_idx_reg   <= bit_idx_next;
      gap_cnt_reg   <= gap_cnt_next;
      man_step_reg  <= man_step_next;
      man_din_reg   <= man_din_next;
      if (step_en) begin
        last_din_reg <= step_din;
      end
    end
  end

  always_comb begin
    state_next     = state_reg;
    pattern_q_next = pattern_q_reg;
    bit_idx_next   = bit_idx_reg;
    gap_cnt_next   = gap_cnt_reg;
    man_step_next  = 1'b0;
    man_din_next   = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        // play has priority; a coincident step press is dropped
        if (play_press) begin
          pattern_q_next = pattern;
          bit_idx_next   = 3'd7;
          state_next     = ST_PLAY;
        end else if (step_press) begin
          man_step_next = 1'b1;
          man_din_next  = sw_din;
        end
      end
      ST_PLAY: begin
        gap_cnt_next = 16'(PLAY_DIV - 2);
        state_next   = ST_GAP;
      end
      ST_GAP: begin
        if (gap_cnt_reg == 16'd0) begin
          if (bit_idx_reg == 3'd0) begin
            state_next = ST_DONE;
          end else begin
            bit_idx_next = bit_idx_reg - 3'd1;
            state_next   = ST_PLAY;
          end
        end else begin
          gap_cnt_next = gap_cnt_reg - 16'd1;
        end
      end
      ST_DONE: begin
`ifdef STEP_SEQ_CTRL_LOOP_EN
        pattern_q_next = pattern;
        bit_idx_next   = 3'd7;
        state_next     = ST_PLAY;
`else
        state_next = ST_IDLE;
`endif
      end
      default: state_next = ST_IDLE;
    endcase
    // a play press while running aborts the run
    if (state_reg != ST_IDLE && play_press) begin
      state_next = ST_IDLE;
    end
  end

  assign step_en  = (state_reg == ST_PLAY) | man_step_reg;
  assign step_din = (state_reg == ST_PLAY) ? pattern_q_reg[bit_idx_reg] : man_din_reg;
  assign busy     = (state_reg != ST_IDLE);

  always_comb begin
    ledr = 16'd0;
    ledr[LED_PAT_LSB +: PATTERN_W] = pattern_q_reg;
    ledr[LED_IDX_LSB +: 3]         = bit_idx_reg;
    ledr[LED_BUSY]                 = busy;
    ledr[LED_DIN]                  = last_din_reg;
    ledr[LED_STATE_LSB +: 2]       = state_reg;
    ledr[LED_ZERO]                 = 1'b0;
  end

endmodule

// File: tb/tb_step_seq_ctrl.sv
// Self-checking bench for step_seq_ctrl with DEB_CYCLES=4, PLAY_DIV=4.
module tb_step_seq_ctrl;

  localparam int DEB = 4;
  localparam int DIV = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        btn_step = 1'b0;
  logic        btn_play = 1'b0;
  logic        sw_din = 1'b0;
  logic [7:0]  pattern = 8'h00;
  logic        step_en;
  logic        step_din;
  logic        busy;
  logic [15:0] ledr;

  step_seq_ctrl #(.DEB_CYCLES(DEB), .PLAY_DIV(DIV)) dut (
    .clk     (clk),
    .rst     (rst),
    .btn_step(btn_step),
    .btn_play(btn_play),
    .sw_din  (sw_din),
    .pattern (pattern),
    .step_en (step_en),
    .step_din(step_din),
    .busy    (busy),
    .ledr    (ledr)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic        din;
    logic [15:0] led;
  } pulse_t;

  typedef struct {
    bit       is_play;
    bit       din;
    bit [7:0] pat;
    int       exp_n;
    bit [7:0] exp_bits;   // pulse k carries exp_bits[7-k]
  } vec_t;

  pulse_t q[$];
  int     cyc = 0;
  int     checks = 0;
  int     errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (step_en) begin
      q.push_back('{cyc, step_din, ledr});
      $display("step_en cyc=%0d din=%0b ledr=%h", cyc, step_din, ledr);
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // hold a button high, release it and let the release debounce settle
  task automatic press(input bit is_play, input int hold);
    if (is_play) btn_play = 1'b1; else btn_step = 1'b1;
    wait_cycles(hold);
    btn_play = 1'b0;
    btn_step = 1'b0;
    wait_cycles(DEB + 6);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 200 && busy; i++) @(negedge clk);
    check("idle_timeout", {31'd0, busy}, 32'd0);
  endtask

  task automatic wait_pulses(input int n);
    for (int i = 0; i < 300 && q.size() < n; i++) @(negedge clk);
    check("pulse_timeout", {31'd0, q.size() >= n}, 32'd1);
  endtask

  vec_t     vecs[6];
  bit [7:0] cur_pat = 8'h00;   // model of pattern_q
  bit       last_din = 1'b0;   // model of the LED copy of the last data bit
  int       n;
  int       rel_cyc;

  initial begin
    // table: play emits pattern MSB first (8 pulses); a step emits sw_din once
    for (int i = 0; i < 6; i++) begin
      vecs[i].is_play = (i % 2 == 1);
      vecs[i].din     = (i == 0) ? 1'b1 : (i == 2) ? 1'b0 : 1'($urandom_range(0, 1));
      vecs[i].pat     = 8'($urandom);
      vecs[i].exp_n   = vecs[i].is_play ? 8 : 1;
      vecs[i].exp_bits = vecs[i].is_play ? vecs[i].pat : {vecs[i].din, 7'd0};
    end
    vecs[1].pat = 8'hA5;
    vecs[1].exp_bits = 8'hA5;

    wait_cycles(3);
    check("rst_step_en", {31'd0, step_en}, 32'd0);
    check("rst_step_din", {31'd0, step_din}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_ledr", {16'd0, ledr}, 32'd0);
    rst = 1'b0;
    wait_cycles(2);

`ifndef STEP_SEQ_CTRL_LOOP_EN
    for (int i = 0; i < 6; i++) begin
      q.delete();
      sw_din  = vecs[i].din;
      pattern = vecs[i].pat;
      press(vecs[i].is_play, 10);
      if (vecs[i].is_play) pattern = ~vecs[i].pat;   // must not affect the run
      wait_idle();
      wait_cycles(2);
      check($sformatf("v%0d_count", i), q.size(), vecs[i].exp_n);
      for (int k = 0; k < q.size() && k < vecs[i].exp_n; k++) begin
        check($sformatf("v%0d_din%0d", i, k), {31'd0, q[k].din}, {31'd0, vecs[i].exp_bits[7-k]});
        check($sformatf("v%0d_led_din%0d", i, k), {31'd0, q[k].led[12]},
              {31'd0, (k == 0) ? last_din : vecs[i].exp_bits[8-k]});
        check($sformatf("v%0d_led_pat%0d", i, k), {24'd0, q[k].led[7:0]},
              {24'd0, vecs[i].is_play ? vecs[i].pat : cur_pat});
        if (vecs[i].is_play) begin
          check($sformatf("v%0d_led_idx%0d", i, k), {29'd0, q[k].led[10:8]}, 32'(7 - k));
          check($sformatf("v%0d_led_busy_st%0d", i, k), {29'd0, q[k].led[15:13]}, 32'd1);
          check($sformatf("v%0d_led_bsy%0d", i, k), {31'd0, q[k].led[11]}, 32'd1);
          if (k > 0) check($sformatf("v%0d_gap%0d", i, k), q[k].cyc - q[k-1].cyc, DIV);
        end else begin
          check($sformatf("v%0d_led_st", i), {29'd0, q[k].led[15:13]}, 32'd0);
          check($sformatf("v%0d_led_bsy", i), {31'd0, q[k].led[11]}, 32'd0);
        end
      end
      if (vecs[i].is_play) cur_pat = vecs[i].pat;
      last_din = vecs[i].is_play ? vecs[i].exp_bits[0] : vecs[i].din;
      check($sformatf("v%0d_ledr_end", i), {16'd0, ledr}, {19'd0, last_din, 1'b0, 3'd0, cur_pat});
      check($sformatf("v%0d_busy_end", i), {31'd0, busy}, 32'd0);
    end

    // bounce shorter than the debounce window
    q.delete();
    for (int i = 0; i < 10; i++) begin
      btn_step = ~btn_step;
      wait_cycles(2);
    end
    btn_step = 1'b0;
    wait_cycles(15);
    check("bounce_no_pulse", q.size(), 0);

    // simultaneous play+step, then a step during the run
    q.delete();
    pattern = 8'h3C;
    btn_play = 1'b1;
    btn_step = 1'b1;
    wait_cycles(10);
    btn_play = 1'b0;
    btn_step = 1'b0;
    wait_cycles(DEB + 6);
    check("simul_busy", {31'd0, busy}, 32'd1);
    press(1'b0, 10);
    wait_idle();
    wait_cycles(10);
    check("simul_count", q.size(), 8);
    for (int k = 0; k < q.size() && k < 8; k++)
      check($sformatf("simul_din%0d", k), {31'd0, q[k].din}, {31'd0, pattern[7-k]});
`else
    // looping: pattern repeats past 8 pulses until stopped
    q.delete();
    pattern = 8'h01;
    press(1'b1, 10);
    wait_pulses(12);
    for (int k = 0; k < 12 && k < q.size(); k++)
      check($sformatf("loop_din%0d", k), {31'd0, q[k].din}, {31'd0, (k % 8) == 7});
    press(1'b1, 10);
    n = q.size();
    check("loop_stop_busy", {31'd0, busy}, 32'd0);
    wait_cycles(40);
    check("loop_stop_count", q.size(), n);
`endif

    // abort with a second play press after the third pulse
    q.delete();
    pattern = 8'hFF;
    btn_play = 1'b1;
    wait_cycles(8);
    btn_play = 1'b0;
    wait_pulses(3);
    wait_cycles(2);
    press(1'b1, 8);
    n = q.size();
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_partial", {31'd0, n < 8}, 32'd1);
    wait_cycles(40);
    check("abort_no_more", q.size(), n);

    // reset in the middle of a gap
    q.delete();
    btn_play = 1'b1;
    wait_cycles(8);
    btn_play = 1'b0;
    wait_pulses(1);
    wait_cycles(1);
    rst = 1'b1;
    @(negedge clk);
    check("rstgap_step_en", {31'd0, step_en}, 32'd0);
    check("rstgap_step_din", {31'd0, step_din}, 32'd0);
    check("rstgap_busy", {31'd0, busy}, 32'd0);
    check("rstgap_ledr", {16'd0, ledr}, 32'd0);
    rst = 1'b0;
    wait_cycles(30);
    check("rstgap_pulses", q.size(), 1);

    // button held across reset release
    btn_step = 1'b1;
    sw_din   = 1'b1;
    rst      = 1'b1;
    wait_cycles(3);
    rst = 1'b0;
    rel_cyc = cyc;
    q.delete();
    wait_cycles(20);
    check("held_count", q.size(), 1);
    if (q.size() > 0) begin
      check("held_delay", {31'd0, (q[0].cyc - rel_cyc) >= DEB}, 32'd1);
      check("held_din", {31'd0, q[0].din}, 32'd1);
    end
    btn_step = 1'b0;
    wait_cycles(12);
    check("held_led_din", {31'd0, ledr[12]}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/step_seq_ctrl.md
STEP_SEQ_CTRL -- requirements
Module: step_seq_ctrl

Interface
REQ-001 SHALL have parameter DEB_CYCLES, default 16: consecutive stable samples required by the debouncer (legal range 2..65535).
REQ-002 SHALL have parameter PLAY_DIV, default 8: clock cycles between automatic step pulses (legal range 2..65535).
REQ-003 SHALL have port clk, input, 1: sole clock; all logic is sampled on the rising edge.
REQ-004 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-005 SHALL have port btn_step, input, 1: raw manual step button, asynchronous to clk.
REQ-006 SHALL have port btn_play, input, 1: raw play/stop button, asynchronous to clk.
REQ-007 SHALL have port sw_din, input, 1: manual data bit for the downstream detector.
REQ-008 SHALL have port pattern, input, 8: auto-play bit pattern, sent MSB first.
REQ-009 SHALL have port step_en, output, 1: single-cycle advance strobe to the downstream sequence detector.
REQ-010 SHALL have port step_din, output, 1: data bit, valid while step_en=1.
REQ-011 SHALL have port busy, output, 1: auto-play in progress.
REQ-012 SHALL have port ledr, output, 16: board LED status.

Function
REQ-013 Each button SHALL use a 2-flop synchronizer, then a debouncer whose level db takes the synchronized value only after DEB_CYCLES consecutive equal samples.
REQ-014 A db 0->1 transition SHALL produce one press event; releases and bounces shorter than DEB_CYCLES SHALL produce none.
REQ-015 The FSM SHALL have exactly four states: IDLE=0, PLAY=1, GAP=2, DONE=3.
REQ-016 In IDLE, a step press SHALL drive step_en=1 and step_din=sw_din for exactly the next cycle, with no state change.
REQ-017 In IDLE, a play press SHALL latch pattern into pattern_q, set bit_idx=7, and enter PLAY.
REQ-018 A play press and a step press in the same IDLE cycle SHALL take the play path; the step press is dropped.
REQ-019 In PLAY (one cycle), step_en SHALL be 1 and step_din SHALL equal pattern_q[bit_idx]; the FSM then enters GAP with its counter loaded to PLAY_DIV-2.
REQ-020 GAP SHALL count down to 0; at 0 it enters DONE if bit_idx=0, otherwise it decrements bit_idx and enters PLAY.
REQ-021 Consecutive auto step_en pulses SHALL be exactly PLAY_DIV cycles apart, with 8 pulses per run.
REQ-022 DONE SHALL last one cycle and then return to IDLE.
REQ-023 busy SHALL be 1 in PLAY, GAP and DONE, and 0 in IDLE.
REQ-024 Step presses while busy SHALL be ignored, not queued.
REQ-025 A play press while busy SHALL abort: the FSM goes to IDLE next cycle and no further step_en is issued.
REQ-026 A pattern change during a run SHALL have no effect; only pattern_q is used.
REQ-027 ledr SHALL be mapped as: [7:0]=pattern_q, [10:8]=bit_idx, [11]=busy, [12]=step_din registered on the last step_en, [14:13]=state, [15]=0.

Reset
REQ-028 On rst=1 at a clock edge, the following SHALL be set: state=IDLE, step_en=0, step_din=0, busy=0, ledr=0, pattern_q=0, bit_idx=0, counters=0, synchronizers=0, db=0.
REQ-029 A reset mid-run SHALL abort immediately, with no step_en in the cycle following reset.
REQ-030 A button held high across reset release SHALL produce a press only after DEB_CYCLES stable samples.

Configuration
REQ-031 When macro STEP_SEQ_CTRL_LOOP_EN is defined, DONE SHALL reload pattern_q from pattern, set bit_idx=7, and enter PLAY; only a play press or rst stops the run.
REQ-032 When STEP_SEQ_CTRL_LOOP_EN is undefined, each run SHALL be one-shot per REQ-022.

Structure
REQ-033 State encodings, ledr field offsets, and the PATTERN_W=8 constant SHALL live in shared package step_seq_pkg.
REQ-034 Synchronizer, debouncer and edge detector SHALL be one sub-module, btn_debounce, instantiated twice.

Verification (DEB_CYCLES=4, PLAY_DIV=4)
REQ-035 Case: sw_din=1, btn_step held high for 10 cycles. Required: exactly one step_en pulse with step_din=1, and ledr[12]=1.
REQ-036 Case: btn_step toggled every 2 cycles for 20 cycles. Required: no step_en pulse.
REQ-037 Case: pattern=8'hA5, play press. Required: 8 step_en pulses 4 cycles apart with step_din 1,0,1,0,0,1,0,1; busy falls one cycle after the 8th pulse's DONE; ledr[7:0]=8'hA5.
REQ-038 Case: play press and step press in the same cycle, followed by a step press during the run. Required: only the 8 pattern pulses appear.
REQ-039 Case: second play press after the 3rd pulse. Required: no further pulses and busy=0. Separately, rst asserted mid-GAP: all outputs 0 the next cycle.
REQ-040 Case: STEP_SEQ_CTRL_LOOP_EN defined, pattern=8'h01. Required: pulses continue past 8 with the pattern repeating, until a play press.
